layer_sched: RTL and testbench



---
 rtl/layer_sched_pkg.sv | 32 +++
 rtl/layer_sched_frame_timer.sv | 33 +++
 rtl/layer_sched.sv | 156 +++++++++++++++
 tb/tb_layer_sched.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/layer_sched_pkg.sv
// layer_sched_pkg: opcodes, CFG register map and reset defaults for the frame scheduler.
// Shared by the scheduler top and its frame timer.
package layer_sched_pkg;

  typedef enum logic [1:0] {
    OP_WRITE  = 2'd0,
    OP_CFG    = 2'd1,
    OP_COMMIT = 2'd2,
    OP_ABORT  = 2'd3
  } op_e;

  // CFG register indices (cmd_addr_in[2:0])
  localparam logic [2:0] REG_T0_H      = 3'd0;
  localparam logic [2:0] REG_T0_L      = 3'd1;
  localparam logic [2:0] REG_T1_H      = 3'd2;
  localparam logic [2:0] REG_T1_L      = 3'd3;
  localparam logic [2:0] REG_RST_LO    = 3'd4;
  localparam logic [2:0] REG_RST_HI    = 3'd5;
  localparam logic [2:0] REG_PERIOD_LO = 3'd6;
  localparam logic [2:0] REG_PERIOD_HI = 3'd7;

  // Reset defaults for the WS2812 timing, latch count and frame period
  localparam logic [7:0]  T0_H_DEF    = 8'd40;
  localparam logic [7:0]  T0_L_DEF    = 8'd85;
  localparam logic [7:0]  T1_H_DEF    = 8'd80;
  localparam logic [7:0]  T1_L_DEF    = 8'd45;
  localparam logic [15:0] RST_CNT_DEF = 16'd5000;
  localparam logic [15:0] PERIOD_DEF  = 16'd0;

  localparam int ELAPSED_W = 24;

endpackage

// File: rtl/layer_sched_frame_timer.sv
// frame_timer: saturating cycles-since-last-frame counter and minimum-period comparator.
// expired_out is combinational from the counter and period; clear takes effect next cycle.
module frame_timer
  import layer_sched_pkg::*;
(
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        clear_in,
  input  logic [15:0] period_in,
  output logic        expired_out
);

  logic [ELAPSED_W-1:0] elapsed_q, elapsed_d;

  // Next count: clear on fire, otherwise count up and stick at all-ones
  always_comb begin
    elapsed_d = elapsed_q;
    if (clear_in) begin
      elapsed_d = '0;
    end else if (elapsed_q != {ELAPSED_W{1'b1}}) begin
      elapsed_d = elapsed_q + 1'b1;
    end
  end

  // Counter starts saturated so the first commit after reset fires at once
  always_ff @(posedge clk_in) begin
    if (rst_in) elapsed_q <= {ELAPSED_W{1'b1}};
    else        elapsed_q <= elapsed_d;
  end

  assign expired_out = (elapsed_q >= {period_in, 8'h00});

endmodule

// File: rtl/layer_sched.sv
// layer_sched: routes host pixel writes to layers, holds timing registers, issues frame starts.
// WRITE strobe and frame pulse are registered (1 cycle); COMMIT waits for the minimum frame period.
// cmd_ready_out drops for WRITE/COMMIT while a commit is pending; CFG and ABORT are always taken.
module layer_sched
  import layer_sched_pkg::*;
#(
  parameter int LAYERS = 8
) (
  input  logic              clk_in,
  input  logic              rst_in,
  input  logic              cmd_valid_in,
  output logic              cmd_ready_out,
  input  logic [1:0]        cmd_op_in,
  input  logic [3:0]        cmd_layer_in,
  input  logic [5:0]        cmd_addr_in,
  input  logic [7:0]        cmd_data_in,
  input  logic [3:0]        cmd_byte_en_in,
  output logic [LAYERS-1:0] wr_en_out,
  output logic [5:0]        wr_addr_out,
  output logic [7:0]        wr_data_out,
  output logic [3:0]        byte_en_out,
  output logic [LAYERS-1:0] frame_rdy_out,
  output logic [7:0]        t0_h_cnt_out,
  output logic [7:0]        t0_l_cnt_out,
  output logic [7:0]        t1_h_cnt_out,
  output logic [7:0]        t1_l_cnt_out,
  output logic [15:0]       rst_cnt_out,
  output logic              pending_out
);

  typedef enum logic {ST_IDLE, ST_PENDING} state_e;

  state_e            state_q;
  logic [LAYERS-1:0] loaded_q, fire_mask_q, wr_en_q, frame_rdy_q;
  logic [5:0]        wr_addr_q;
  logic [7:0]        wr_data_q;
  logic [3:0]        byte_en_q;
  logic [7:0]        t0_h_q, t0_l_q, t1_h_q, t1_l_q;
  logic [15:0]       rst_cnt_q, period_q;

  op_e               op;
  logic [LAYERS-1:0] layer_hot;
  logic              abort_acc, expired, fire;

  assign op            = op_e'(cmd_op_in);
  assign cmd_ready_out = (state_q == ST_IDLE) || (op == OP_CFG) || (op == OP_ABORT);
  assign abort_acc     = cmd_valid_in && (op == OP_ABORT);
  // ABORT in the same cycle as the period expiring cancels the frame
  assign fire          = (state_q == ST_PENDING) && expired && !abort_acc;

  // Decode target layer; layers beyond LAYERS decode to nothing so the write is dropped
  always_comb begin
    layer_hot = '0;
    for (int i = 0; i < LAYERS; i++) begin
      layer_hot[i] = (cmd_layer_in == 4'(i));
    end
  end

  frame_timer u_frame_timer (
    .clk_in      (clk_in),
    .rst_in      (rst_in),
    .clear_in    (fire),
    .period_in   (period_q),
    .expired_out (expired)
  );

  // Scheduler FSM with registered write strobe, write bus and frame pulse
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q     <= ST_IDLE;
      loaded_q    <= '0;
      fire_mask_q <= '0;
      wr_en_q     <= '0;
      frame_rdy_q <= '0;
      wr_addr_q   <= '0;
      wr_data_q   <= '0;
      byte_en_q   <= '0;
    end else begin
      wr_en_q     <= '0;
      frame_rdy_q <= '0;
      case (state_q)
        ST_IDLE: begin
          if (cmd_valid_in) begin
            case (op)
              OP_WRITE: begin
                wr_en_q <= layer_hot;
                if (|layer_hot) begin
                  wr_addr_q <= cmd_addr_in;
                  wr_data_q <= cmd_data_in;
                  byte_en_q <= cmd_byte_en_in;
                  loaded_q  <= loaded_q | layer_hot;
                end
              end
              OP_COMMIT: begin
                if (|loaded_q) begin
                  fire_mask_q <= loaded_q;
                  state_q     <= ST_PENDING;
                end
              end
              OP_ABORT: loaded_q <= '0;
              default: ;
            endcase
          end
        end
        ST_PENDING: begin
          if (abort_acc) begin
            loaded_q <= '0;
            state_q  <= ST_IDLE;
          end else if (fire) begin
            frame_rdy_q <= fire_mask_q;
            loaded_q    <= '0;
            state_q     <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  // Configuration register file; CFG is accepted in every state
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      t0_h_q    <= T0_H_DEF;
      t0_l_q    <= T0_L_DEF;
      t1_h_q    <= T1_H_DEF;
      t1_l_q    <= T1_L_DEF;
      rst_cnt_q <= RST_CNT_DEF;
      period_q  <= PERIOD_DEF;
    end else if (cmd_valid_in && (op == OP_CFG)) begin
      case (cmd_addr_in[2:0])
        REG_T0_H:      t0_h_q          <= cmd_data_in;
        REG_T0_L:      t0_l_q          <= cmd_data_in;
        REG_T1_H:      t1_h_q          <= cmd_data_in;
        REG_T1_L:      t1_l_q          <= cmd_data_in;
        REG_RST_LO:    rst_cnt_q[7:0]  <= cmd_data_in;
        REG_RST_HI:    rst_cnt_q[15:8] <= cmd_data_in;
        REG_PERIOD_LO: period_q[7:0]   <= cmd_data_in;
        REG_PERIOD_HI: period_q[15:8]  <= cmd_data_in;
        default: ;
      endcase
    end
  end

  assign wr_en_out     = wr_en_q;
  assign wr_addr_out   = wr_addr_q;
  assign wr_data_out   = wr_data_q;
  assign byte_en_out   = byte_en_q;
  assign frame_rdy_out = frame_rdy_q;
  assign t0_h_cnt_out  = t0_h_q;
  assign t0_l_cnt_out  = t0_l_q;
  assign t1_h_cnt_out  = t1_h_q;
  assign t1_l_cnt_out  = t1_l_q;
  assign rst_cnt_out   = rst_cnt_q;
  assign pending_out   = (state_q == ST_PENDING);

endmodule

// File: tb/tb_layer_sched.sv
// tb_layer_sched: directed and randomized checks of layer_sched against a cycle-count model.
// The model predicts frame pulses from "cycles since last pulse" arithmetic.
module tb_layer_sched;

  localparam logic [1:0] OP_W = 2'd0, OP_C = 2'd1, OP_M = 2'd2, OP_A = 2'd3;
  localparam longint NEG_INF = -64'sd1000000000;

  logic        clk_in = 1'b0;
  logic        rst_in = 1'b1;
  logic        cmd_valid_in = 1'b0;
  logic        cmd_ready_out;
  logic [1:0]  cmd_op_in = 2'd0;
  logic [3:0]  cmd_layer_in = 4'd0;
  logic [5:0]  cmd_addr_in = 6'd0;
  logic [7:0]  cmd_data_in = 8'd0;
  logic [3:0]  cmd_byte_en_in = 4'd0;
  logic [7:0]  wr_en_out, frame_rdy_out;
  logic [5:0]  wr_addr_out;
  logic [7:0]  wr_data_out, t0_h_cnt_out, t0_l_cnt_out, t1_h_cnt_out, t1_l_cnt_out;
  logic [3:0]  byte_en_out;
  logic [15:0] rst_cnt_out;
  logic        pending_out;

  layer_sched #(.LAYERS(8)) dut (
    .clk_in(clk_in), .rst_in(rst_in),
    .cmd_valid_in(cmd_valid_in), .cmd_ready_out(cmd_ready_out),
    .cmd_op_in(cmd_op_in), .cmd_layer_in(cmd_layer_in), .cmd_addr_in(cmd_addr_in),
    .cmd_data_in(cmd_data_in), .cmd_byte_en_in(cmd_byte_en_in),
    .wr_en_out(wr_en_out), .wr_addr_out(wr_addr_out), .wr_data_out(wr_data_out),
    .byte_en_out(byte_en_out), .frame_rdy_out(frame_rdy_out),
    .t0_h_cnt_out(t0_h_cnt_out), .t0_l_cnt_out(t0_l_cnt_out),
    .t1_h_cnt_out(t1_h_cnt_out), .t1_l_cnt_out(t1_l_cnt_out),
    .rst_cnt_out(rst_cnt_out), .pending_out(pending_out)
  );

  always #5 clk_in = ~clk_in;

  longint cyc = 0;
  always @(posedge clk_in) cyc <= cyc + 1;

  // Every observed frame pulse, with the cycle it was seen in
  longint     pq_cyc[$];
  logic [7:0] pq_mask[$];
  always @(negedge clk_in) begin
    if (frame_rdy_out !== 8'h00) begin
      pq_cyc.push_back(cyc);
      pq_mask.push_back(frame_rdy_out);
    end
  end

  int tests = 0;
  int failed = 0;

  // Reference state: layers loaded since last frame, period, cycle of last pulse
  logic [7:0]  m_loaded = 8'h00;
  logic [15:0] m_period = 16'h0000;
  longint      p_last = NEG_INF;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_in);
    #1;
  endtask

  // Present one command, hold it until taken (bounded), return acceptance cycle
  task automatic send(input logic [1:0] op, input logic [3:0] lyr, input logic [5:0] ad,
                      input logic [7:0] dt, input logic [3:0] be, output longint acc);
    int n = 0;
    cmd_op_in = op; cmd_layer_in = lyr; cmd_addr_in = ad;
    cmd_data_in = dt; cmd_byte_en_in = be; cmd_valid_in = 1'b1;
    #1;
    while (cmd_ready_out !== 1'b1 && n < 3000) begin step(); n++; end
    chk("cmd_accept", {63'd0, cmd_ready_out}, 64'd1);
    acc = cyc;
    step();
    cmd_valid_in = 1'b0;
  endtask

  task automatic do_write(input logic [3:0] lyr, input logic [5:0] ad, input logic [7:0] dt,
                          input logic [3:0] be, output longint acc);
    logic [7:0] exp_en;
    send(OP_W, lyr, ad, dt, be, acc);
    exp_en = (lyr < 4'd8) ? (8'h01 << lyr) : 8'h00;
    chk("wr_en", wr_en_out, exp_en);
    if (lyr < 4'd8) begin
      chk("wr_addr", wr_addr_out, ad);
      chk("wr_data", wr_data_out, dt);
      chk("byte_en", byte_en_out, be);
      m_loaded = m_loaded | exp_en;
    end
  endtask

  task automatic do_cfg(input logic [2:0] idx, input logic [7:0] v, output longint acc);
    send(OP_C, 4'd0, {3'd0, idx}, v, 4'd0, acc);
    if (idx == 3'd6) m_period[7:0] = v;
    if (idx == 3'd7) m_period[15:8] = v;
  endtask

  // Earliest fire cycle is the later of "state pending" and "period elapsed since last pulse"
  function automatic longint fire_cycle(input longint acc);
    longint f;
    f = acc + 1;
    if (p_last + longint'(m_period) * 256 > f) f = p_last + longint'(m_period) * 256;
    return f;
  endfunction

  // COMMIT; returns predicted pulse cycle and mask (mask 0 means ignored)
  task automatic do_commit(output longint acc, output longint pc, output logic [7:0] pm);
    send(OP_M, 4'd0, 6'd0, 8'd0, 4'd0, acc);
    pm = m_loaded;
    pc = fire_cycle(acc) + 1;
    chk("pending_after_commit", {63'd0, pending_out}, {63'd0, (m_loaded != 8'h00)});
    m_loaded = 8'h00;
  endtask

  task automatic expect_pulse(input longint ec, input logic [7:0] em);
    int n = 0;
    while (cyc < ec + 1 && n < 5000) begin step(); n++; end
    chk("pulse_count", pq_cyc.size(), 64'd1);
    if (pq_cyc.size() > 0) begin
      chk("pulse_cycle", pq_cyc[0], ec);
      chk("pulse_mask", pq_mask[0], em);
    end
    pq_cyc.delete(); pq_mask.delete();
  endtask

  task automatic expect_none(input string tag);
    chk(tag, pq_cyc.size(), 64'd0);
    pq_cyc.delete(); pq_mask.delete();
  endtask

  task automatic do_reset();
    cmd_valid_in = 1'b0;
    rst_in = 1'b1;
    step(); step();
    rst_in = 1'b0;
    m_loaded = 8'h00; m_period = 16'h0000; p_last = NEG_INF;
  endtask

  task automatic check_defaults(input string tag);
    chk({tag, "_t0h"}, t0_h_cnt_out, 64'd40);
    chk({tag, "_t0l"}, t0_l_cnt_out, 64'd85);
    chk({tag, "_t1h"}, t1_h_cnt_out, 64'd80);
    chk({tag, "_t1l"}, t1_l_cnt_out, 64'd45);
    chk({tag, "_rstcnt"}, rst_cnt_out, 64'd5000);
    chk({tag, "_wr_en"}, wr_en_out, 64'd0);
    chk({tag, "_frame_rdy"}, frame_rdy_out, 64'd0);
    chk({tag, "_pending"}, {63'd0, pending_out}, 64'd0);
    chk({tag, "_ready"}, {63'd0, cmd_ready_out}, 64'd1);
  endtask

  initial begin
    longint acc, pc, c0, f;
    logic [7:0] pm, v;
    logic [2:0] idx;
    logic [7:0] obs;
    int n;

    // Reset defaults
    do_reset();
    check_defaults("reset");
    chk("reset_wr_addr", wr_addr_out, 64'd0);
    chk("reset_wr_data", wr_data_out, 64'd0);
    chk("reset_byte_en", byte_en_out, 64'd0);
    pq_cyc.delete(); pq_mask.delete();

    // WRITE routing, single-cycle strobe, dropped out-of-range layer
    do_write(4'd3, 6'h2A, 8'h5C, 4'b0010, acc);
    step();
    chk("strobe_one_cycle", wr_en_out, 64'd0);
    do_write(4'd9, 6'h11, 8'h22, 4'hF, acc);

    // ABORT in idle empties the loaded set
    send(OP_A, 4'd0, 6'd0, 8'd0, 4'd0, acc);
    m_loaded = 8'h00;

    // Commit layers 0 and 5 with period 0
    do_write(4'd0, 6'h01, 8'hA0, 4'h1, acc);
    do_write(4'd5, 6'h02, 8'hA5, 4'h3, acc);
    do_commit(acc, pc, pm);
    p_last = pc;
    // WRITE right after commit stalls until the pulse cycle
    do_write(4'd1, 6'h03, 8'hB1, 4'h8, acc);
    chk("write_at_pulse_cycle", acc, pc);
    expect_pulse(pc, pm);
    chk("first_mask_value", pm, 64'h21);

    // Period 2 -> next frame 512 cycles after the previous pulse
    do_cfg(3'd6, 8'd2, acc);
    do_commit(acc, pc, pm);
    chk("pending_period2", {63'd0, pending_out}, 64'd1);
    c0 = cyc;
    do_cfg(3'd4, 8'h34, acc);
    chk("cfg_in_pending_no_stall", acc, c0);
    chk("rst_cnt_lo", rst_cnt_out, 64'h1388 & 64'hFF00 | 64'h34);
    cmd_op_in = OP_W; #1;
    chk("write_stalls_pending", {63'd0, cmd_ready_out}, 64'd0);
    cmd_op_in = OP_C; #1;
    chk("cfg_ready_pending", {63'd0, cmd_ready_out}, 64'd1);
    do_write(4'd2, 6'h04, 8'hC2, 4'h4, acc);
    chk("stalled_write_accept", acc, pc);
    expect_pulse(pc, pm);
    chk("second_pulse_gap", pc - p_last, 64'd513);
    p_last = pc;
    do_cfg(3'd5, 8'h12, acc);
    chk("rst_cnt_full", rst_cnt_out, 64'h1234);

    // ABORT while pending, then COMMIT with nothing loaded is ignored
    do_cfg(3'd7, 8'h04, acc);
    do_commit(acc, pc, pm);
    step(); step(); step();
    send(OP_A, 4'd0, 6'd0, 8'd0, 4'd0, acc);
    chk("abort_clears_pending", {63'd0, pending_out}, 64'd0);
    step(); step(); step();
    expect_none("abort_no_pulse");
    do_commit(acc, pc, pm);
    step(); step();
    expect_none("empty_commit_no_pulse");

    // ABORT presented exactly in the fire cycle
    do_cfg(3'd7, 8'h00, acc);
    do_cfg(3'd6, 8'h01, acc);
    do_write(4'd4, 6'h05, 8'hD4, 4'h2, acc);
    do_commit(acc, pc, pm);
    f = pc - 1;
    n = 0;
    while (cyc < f && n < 3000) begin step(); n++; end
    c0 = cyc;
    send(OP_A, 4'd0, 6'd0, 8'd0, 4'd0, acc);
    chk("abort_fire_cycle_accept", acc, f);
    chk("abort_fire_pending", {63'd0, pending_out}, 64'd0);
    step(); step(); step();
    expect_none("abort_fire_no_pulse");

    // Reset in the middle of a long pending period
    do_cfg(3'd0, 8'd7, acc);
    chk("cfg_t0h", t0_h_cnt_out, 64'd7);
    do_cfg(3'd7, 8'h10, acc);
    do_write(4'd6, 6'h06, 8'hE6, 4'h1, acc);
    do_commit(acc, pc, pm);
    step(); step();
    do_reset();
    check_defaults("midreset");
    step(); step(); step();
    expect_none("midreset_no_pulse");
    // Period back to 0 and counter saturated: fire at minimum latency
    do_write(4'd7, 6'h07, 8'hF7, 4'h2, acc);
    do_commit(acc, pc, pm);
    chk("post_reset_min_latency", pc - acc, 64'd2);
    expect_pulse(pc, pm);
    p_last = pc;

    // Randomized rounds: timing CFG, random writes, occasional idle abort, commit
    for (int r = 0; r < 8; r++) begin
      idx = 3'($urandom_range(0, 3));
      v = 8'($urandom);
      do_cfg(idx, v, acc);
      case (idx)
        3'd0: obs = t0_h_cnt_out;
        3'd1: obs = t0_l_cnt_out;
        3'd2: obs = t1_h_cnt_out;
        default: obs = t1_l_cnt_out;
      endcase
      chk("rand_cfg_timing", obs, v);
      do_cfg(3'd6, 8'($urandom_range(0, 2)), acc);
      for (int w = 0; w < int'($urandom_range(1, 4)); w++) begin
        do_write(4'($urandom_range(0, 15)), 6'($urandom), 8'($urandom), 4'($urandom), acc);
      end
      if ($urandom_range(0, 3) == 0) begin
        send(OP_A, 4'd0, 6'd0, 8'd0, 4'd0, acc);
        m_loaded = 8'h00;
      end
      do_commit(acc, pc, pm);
      if (pm != 8'h00) begin
        expect_pulse(pc, pm);
        p_last = pc;
      end else begin
        step(); step();
        expect_none("rand_empty_commit");
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
